// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared types and widths for the layer ROM arbiter
package layer_pkg;

  localparam int WORD_W      = 32;
  localparam int TILE_ADDR_W = 20;

  typedef enum logic {
    CLI_A = 1'b0,
    CLI_B = 1'b1
  } client_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // The client that gets priority after c has been served
  function automatic client_e other_client(input client_e c);
    return (c == CLI_A) ? CLI_B : CLI_A;
  endfunction

endpackage

// File: rtl/rom_req_slot.sv
// rtl/rom_req_slot.sv - per-layer pending request, address, stale and overrun tracking
module rom_req_slot
  import layer_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req,
  input  logic [TILE_ADDR_W-1:0] i_addr,
  input  logic                   i_issue,
  input  logic                   i_owner_busy,
  output logic                   o_pend,
  output logic [TILE_ADDR_W-1:0] o_addr,
  output logic                   o_stale_now,
  output logic                   o_overrun
);

  logic                   r_pend;
  logic [TILE_ADDR_W-1:0] r_addr;
  logic                   r_stale;
  logic                   r_overrun;

  // Capture the latest request; the issue clears pend unless a new request lands on the same edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend    <= 1'b0;
      r_addr    <= '0;
      r_stale   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_req && r_pend && !i_issue;
      if (i_req) begin
        r_pend <= 1'b1;
        r_addr <= i_addr;
      end else if (i_issue) begin
        r_pend <= 1'b0;
      end
      if (i_issue) begin
        r_stale <= 1'b0;
      end else if (i_req && i_owner_busy) begin
        r_stale <= 1'b1;
      end
    end
  end

  // A request arriving on the ack edge already supersedes the transfer completing on it
  assign o_stale_now = r_stale | (i_req & i_owner_busy);
  assign o_pend      = r_pend;
  assign o_addr      = r_addr;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/layer_rom_arbiter.sv
// rtl/layer_rom_arbiter.sv - round-robin arbiter of two tilemap layers onto one SDRAM read port
module layer_rom_arbiter
  import layer_pkg::*;
#(
  parameter int                ADDR_W = 25,
  parameter logic [ADDR_W-1:0] A_BASE = 25'h0000000,
  parameter logic [ADDR_W-1:0] B_BASE = 25'h0100000
) (
  input  logic                   CLK_32M,
  input  logic                   RESET_N,
  input  logic                   a_req,
  input  logic [TILE_ADDR_W-1:0] a_addr,
  output logic [WORD_W-1:0]      a_data,
  output logic                   a_rdy,
  input  logic                   b_req,
  input  logic [TILE_ADDR_W-1:0] b_addr,
  output logic [WORD_W-1:0]      b_data,
  output logic                   b_rdy,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_req,
  input  logic                   mem_ack,
  input  logic [WORD_W-1:0]      mem_data,
  output logic                   a_overrun,
  output logic                   b_overrun
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  client_e                r_owner;
  client_e                r_rr;
  logic                   r_mem_req;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [WORD_W-1:0]      r_a_data;
  logic [WORD_W-1:0]      r_b_data;
  logic                   r_a_rdy;
  logic                   r_b_rdy;

  logic                   w_pend_a;
  logic                   w_pend_b;
  logic [TILE_ADDR_W-1:0] w_addr_a;
  logic [TILE_ADDR_W-1:0] w_addr_b;
  logic                   w_stale_now_a;
  logic                   w_stale_now_b;
  logic                   w_issue_a;
  logic                   w_issue_b;
  logic                   w_done;
  logic                   w_deliver_a;
  logic                   w_deliver_b;
  logic                   w_owner_busy_a;
  logic                   w_owner_busy_b;
  logic [ADDR_W-1:0]      w_byte_a;
  logic [ADDR_W-1:0]      w_byte_b;

  assign w_owner_busy_a = (r_state == ST_BUSY) && (r_owner == CLI_A);
  assign w_owner_busy_b = (r_state == ST_BUSY) && (r_owner == CLI_B);

  rom_req_slot u_slot_a (
    .i_clk        (CLK_32M),
    .i_rst_n      (RESET_N),
    .i_req        (a_req),
    .i_addr       (a_addr),
    .i_issue      (w_issue_a),
    .i_owner_busy (w_owner_busy_a),
    .o_pend       (w_pend_a),
    .o_addr       (w_addr_a),
    .o_stale_now  (w_stale_now_a),
    .o_overrun    (a_overrun)
  );

  rom_req_slot u_slot_b (
    .i_clk        (CLK_32M),
    .i_rst_n      (RESET_N),
    .i_req        (b_req),
    .i_addr       (b_addr),
    .i_issue      (w_issue_b),
    .i_owner_busy (w_owner_busy_b),
    .o_pend       (w_pend_b),
    .o_addr       (w_addr_b),
    .o_stale_now  (w_stale_now_b),
    .o_overrun    (b_overrun)
  );

  // Word address to byte address; wraps silently at 2^ADDR_W
  assign w_byte_a = A_BASE + ADDR_W'({w_addr_a, 2'b00});
  assign w_byte_b = B_BASE + ADDR_W'({w_addr_b, 2'b00});

  // FSM state register
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: pick a client in IDLE, wait for the ack in BUSY and decide whether to deliver
  always_comb begin
    w_state_nxt = r_state;
    w_issue_a   = 1'b0;
    w_issue_b   = 1'b0;
    w_done      = 1'b0;
    w_deliver_a = 1'b0;
    w_deliver_b = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_a && (!w_pend_b || (r_rr == CLI_A))) begin
          w_issue_a   = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (w_pend_b) begin
          w_issue_b   = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
          if (r_owner == CLI_A) begin
            w_deliver_a = !w_stale_now_a;
          end else begin
            w_deliver_b = !w_stale_now_b;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory request, ownership, round-robin pointer and returned data
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_owner    <= CLI_A;
      r_rr       <= CLI_A;
      r_a_data   <= '0;
      r_b_data   <= '0;
      r_a_rdy    <= 1'b0;
      r_b_rdy    <= 1'b0;
    end else begin
      r_a_rdy <= w_deliver_a;
      r_b_rdy <= w_deliver_b;
      if (w_deliver_a) begin
        r_a_data <= mem_data;
      end
      if (w_deliver_b) begin
        r_b_data <= mem_data;
      end
      if (w_issue_a) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_byte_a;
        r_owner    <= CLI_A;
      end else if (w_issue_b) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_byte_b;
        r_owner    <= CLI_B;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
        r_rr      <= other_client(r_owner);
      end
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign a_data   = r_a_data;
  assign b_data   = r_b_data;
  assign a_rdy    = r_a_rdy;
  assign b_rdy    = r_b_rdy;

endmodule

// File: tb/tb_layer_rom_arbiter.sv
// tb/tb_layer_rom_arbiter.sv - self-checking bench for layer_rom_arbiter
module tb_layer_rom_arbiter;

  logic        CLK_32M = 1'b0;
  logic        RESET_N = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [19:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_data, b_data;
  logic        a_rdy, b_rdy;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        a_overrun, b_overrun;

  layer_rom_arbiter dut (
    .CLK_32M  (CLK_32M),
    .RESET_N  (RESET_N),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_rdy    (a_rdy),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_rdy    (b_rdy),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .a_overrun(a_overrun),
    .b_overrun(b_overrun)
  );

  always #5 CLK_32M = ~CLK_32M;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int a_rdy_cnt = 0, b_rdy_cnt = 0, a_ovr_cnt = 0, b_ovr_cnt = 0;
  bit chk_en = 1'b0;

  always @(posedge CLK_32M) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_pend[2], m_stale[2], m_rdy[2], m_ovr[2];
  logic [19:0] m_addr[2];
  logic [31:0] m_data[2];
  logic        m_busy, m_mreq;
  int          m_owner, m_rr;
  logic [24:0] m_maddr;
  logic [24:0] base_of[2];

  initial begin
    base_of[0] = 25'h0000000;
    base_of[1] = 25'h0100000;
  end

  task model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pend[c] = 0; m_stale[c] = 0; m_rdy[c] = 0; m_ovr[c] = 0;
      m_addr[c] = '0; m_data[c] = '0;
    end
    m_busy = 0; m_mreq = 0; m_owner = 0; m_rr = 0; m_maddr = '0;
  endtask

  always @(posedge CLK_32M or negedge RESET_N) begin : mdl
    logic        req[2];
    logic [19:0] ra[2];
    logic        pend_old[2];
    logic        busy_old;
    int          owner_old, iss;
    if (!RESET_N) begin
      model_reset();
    end else begin
      req[0] = a_req; req[1] = b_req; ra[0] = a_addr; ra[1] = b_addr;
      busy_old = m_busy; owner_old = m_owner;
      for (int c = 0; c < 2; c++) begin
        m_rdy[c] = 0; m_ovr[c] = 0; pend_old[c] = m_pend[c];
      end
      iss = -1;
      if (!m_busy) begin
        if (m_pend[0] && m_pend[1]) iss = m_rr;
        else if (m_pend[0]) iss = 0;
        else if (m_pend[1]) iss = 1;
      end
      if (m_busy && mem_ack) begin
        if (!m_stale[m_owner] && !req[m_owner]) begin
          m_data[m_owner] = mem_data;
          m_rdy[m_owner]  = 1;
        end
        m_busy = 0; m_mreq = 0; m_rr = 1 - m_owner;
      end
      if (iss >= 0) begin
        m_maddr = 25'(32'(base_of[iss]) + 32'(m_addr[iss]) * 4);
        m_mreq = 1; m_owner = iss; m_busy = 1;
        m_pend[iss] = 0; m_stale[iss] = 0;
      end
      for (int c = 0; c < 2; c++) begin
        if (req[c]) begin
          if (pend_old[c] && iss != c) m_ovr[c] = 1;
          if (busy_old && owner_old == c) m_stale[c] = 1;
          m_pend[c] = 1;
          m_addr[c] = ra[c];
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK_32M) begin
    if (RESET_N) begin
      if (a_rdy) a_rdy_cnt++;
      if (b_rdy) b_rdy_cnt++;
      if (a_overrun) a_ovr_cnt++;
      if (b_overrun) b_ovr_cnt++;
      if (chk_en) begin
        chk("mem_req", mem_req, m_mreq);
        chk("mem_addr", mem_addr, m_maddr);
        chk("a_rdy", a_rdy, m_rdy[0]);
        chk("b_rdy", b_rdy, m_rdy[1]);
        chk("a_data", a_data, m_data[0]);
        chk("b_data", b_data, m_data[1]);
        chk("a_overrun", a_overrun, m_ovr[0]);
        chk("b_overrun", b_overrun, m_ovr[1]);
      end
    end
  end

  // ---------------- SDRAM responder ----------------
  int          rsp_lat = 5, rsp_cnt = 0, cur_lat = 1;
  bit          rsp_rand_lat = 0, rsp_rand_data = 0, rsp_stray = 0;
  logic [31:0] rsp_val = '0;
  int          stray_req = 0, stray_done = 0;

  always @(negedge CLK_32M) begin
    mem_ack = 1'b0;
    if (!RESET_N) begin
      rsp_cnt = 0;
    end else if (stray_done != stray_req) begin
      stray_done++;
      mem_ack = 1'b1; mem_data = $urandom;
    end else if (mem_req) begin
      if (rsp_cnt == 0) cur_lat = rsp_rand_lat ? int'($urandom_range(1, 6)) : rsp_lat;
      rsp_cnt++;
      if (rsp_cnt >= cur_lat) begin
        mem_ack = 1'b1;
        mem_data = rsp_rand_data ? $urandom : rsp_val;
        rsp_cnt = 0;
      end
    end else if (rsp_stray && $urandom_range(0, 15) == 0) begin
      mem_ack = 1'b1; mem_data = $urandom;
    end
  end

  // ---------------- helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge CLK_32M);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return mem_req;
      1: return a_rdy;
      default: return b_rdy;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic v, input string nm);
    int k = 0;
    while (sig(sel) !== v && k < 200) begin
      @(negedge CLK_32M);
      k++;
    end
    if (sig(sel) !== v) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: got %b expected %b", nm, sig(sel), v);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    cycles(2);
    RESET_N = 1'b1;
    cycles(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0, b0, oa0, ob0;
    #2 RESET_N = 1'b0;
    cycles(3);
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset mem_addr", mem_addr, 25'h0);
    chk("reset a_rdy", a_rdy, 1'b0);
    chk("reset b_rdy", b_rdy, 1'b0);
    chk("reset a_data", a_data, 32'h0);
    chk("reset overrun", {a_overrun, b_overrun}, 2'b00);
    RESET_N = 1'b1;
    cycles(1);
    chk_en = 1'b1;

    // 1: single fetch
    rsp_lat = 5; rsp_val = 32'hDEADBEEF;
    a0 = a_rdy_cnt; b0 = b_rdy_cnt;
    a_req = 1; a_addr = 20'h00010; cycles(1); a_req = 0;
    wait_for(0, 1, "t1 mem_req");
    chk("t1 mem_addr", mem_addr, 25'h0000040);
    wait_for(1, 1, "t1 a_rdy");
    chk("t1 a_data", a_data, 32'hDEADBEEF);
    cycles(2);
    chk("t1 a_rdy count", a_rdy_cnt - a0, 1);
    chk("t1 b_rdy count", b_rdy_cnt - b0, 0);

    // 2: contention from reset state
    do_reset();
    a0 = a_rdy_cnt; b0 = b_rdy_cnt;
    a_req = 1; a_addr = 20'h1; b_req = 1; b_addr = 20'h2; cycles(1);
    a_req = 0; b_req = 0;
    wait_for(0, 1, "t2 first mem_req");
    chk("t2 first mem_addr", mem_addr, 25'h0000004);
    wait_for(0, 0, "t2 mem_req drop");
    wait_for(0, 1, "t2 second mem_req");
    chk("t2 second mem_addr", mem_addr, 25'h0100008);
    wait_for(2, 1, "t2 b_rdy");
    cycles(2);
    chk("t2 a_rdy count", a_rdy_cnt - a0, 1);
    chk("t2 b_rdy count", b_rdy_cnt - b0, 1);

    // 3: overrun while B owns the port
    oa0 = a_ovr_cnt;
    b_req = 1; b_addr = 20'h9; cycles(1); b_req = 0;
    wait_for(0, 1, "t3 b mem_req");
    chk("t3 b mem_addr", mem_addr, 25'h0100024);
    a_req = 1; a_addr = 20'h5; cycles(1);
    a_addr = 20'h6; cycles(1); a_req = 0;
    wait_for(0, 0, "t3 mem_req drop");
    wait_for(0, 1, "t3 a mem_req");
    chk("t3 a mem_addr", mem_addr, 25'h0000018);
    wait_for(1, 1, "t3 a_rdy");
    cycles(2);
    chk("t3 a_overrun count", a_ovr_cnt - oa0, 1);

    // 4: stale result dropped
    rsp_val = 32'h11111111; a0 = a_rdy_cnt;
    a_req = 1; a_addr = 20'h3; cycles(1); a_req = 0;
    wait_for(0, 1, "t4 first mem_req");
    chk("t4 first mem_addr", mem_addr, 25'h000000C);
    a_req = 1; a_addr = 20'h4; cycles(1); a_req = 0;
    wait_for(0, 0, "t4 mem_req drop");
    rsp_val = 32'h22222222;
    wait_for(0, 1, "t4 second mem_req");
    chk("t4 second mem_addr", mem_addr, 25'h0000010);
    wait_for(1, 1, "t4 a_rdy");
    chk("t4 a_data", a_data, 32'h22222222);
    cycles(2);
    chk("t4 a_rdy count", a_rdy_cnt - a0, 1);

    // 5: reset during BUSY, then a stray ack
    a0 = a_rdy_cnt;
    a_req = 1; a_addr = 20'h7; cycles(1); a_req = 0;
    wait_for(0, 1, "t5 mem_req");
    cycles(2);
    RESET_N = 1'b0;
    #1;
    chk("t5 async mem_req", mem_req, 1'b0);
    chk("t5 async mem_addr", mem_addr, 25'h0);
    cycles(2);
    RESET_N = 1'b1;
    stray_req++;
    cycles(4);
    chk("t5 a_rdy after stray ack", a_rdy_cnt - a0, 0);
    chk("t5 mem_req idle", mem_req, 1'b0);

    // 6: back-to-back alternating, ack latency 2
    rsp_lat = 2; rsp_rand_data = 1;
    a0 = a_rdy_cnt; b0 = b_rdy_cnt; oa0 = a_ovr_cnt; ob0 = b_ovr_cnt;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin a_req = 1; a_addr = 20'($urandom); end
      else begin b_req = 1; b_addr = 20'($urandom); end
      cycles(1);
      a_req = 0; b_req = 0;
      cycles(7);
    end
    cycles(10);
    chk("t6 a_rdy count", a_rdy_cnt - a0, 4);
    chk("t6 b_rdy count", b_rdy_cnt - b0, 4);
    chk("t6 overruns", (a_ovr_cnt - oa0) + (b_ovr_cnt - ob0), 0);

    // randomized traffic with random latency, stray acks and one reset
    rsp_rand_lat = 1; rsp_stray = 1;
    for (int k = 0; k < 3000; k++) begin
      a_req = ($urandom_range(0, 5) == 0); a_addr = 20'($urandom);
      b_req = ($urandom_range(0, 5) == 0); b_addr = 20'($urandom);
      if (k == 1500) begin
        a_req = 0; b_req = 0;
        RESET_N = 1'b0; cycles(3); RESET_N = 1'b1;
      end
      cycles(1);
    end
    a_req = 0; b_req = 0;
    cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
